// File: rtl/seq_booth_multiplier.sv
// Iterative Booth multiplier that reuses one add/subtract row across cycles, with valid/ready on both sides.
// Radix-2 by default; define SEQ_BOOTH_RADIX4_EN to select radix-4 (modified Booth) recoding.
module seq_booth_multiplier #(
  parameter int X_WIDTH = 8,
  parameter int Y_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [X_WIDTH-1:0]         x_in,
  input  logic [Y_WIDTH-1:0]         y_in,
  input  logic                       signed_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [X_WIDTH+Y_WIDTH-1:0] z_out,
  output logic                       busy
);

  localparam int ZW = X_WIDTH + Y_WIDTH;
  localparam int PW = ZW + 2;
  localparam int YE = Y_WIDTH + 1;
`ifdef SEQ_BOOTH_RADIX4_EN
  localparam int YR   = YE + (YE % 2);
  localparam int ITER = YR / 2;
`else
  localparam int YR   = YE;
  localparam int ITER = YE;
`endif
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   p_q, p_d, m_q, m_d, p_step;
  logic [YR-1:0]   y_q, y_d;
  logic            hist_q, hist_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ZW-1:0]   z_q, z_d;
  logic            accept, last_step, x_sx, y_sx;

  assign accept    = (state_q == IDLE) && in_valid;
  assign last_step = (state_q == BUSY) && (cnt_q == CW'(ITER - 1));
  assign x_sx      = signed_op & x_in[X_WIDTH-1];
  assign y_sx      = signed_op & y_in[Y_WIDTH-1];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      BUSY:    busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // One Booth step: m_q already holds the extended X shifted to the current digit position.
  always_comb begin
    p_step = p_q;
`ifdef SEQ_BOOTH_RADIX4_EN
    case ({y_q[1], y_q[0], hist_q})
      3'b001, 3'b010: p_step = p_q + m_q;
      3'b011:         p_step = p_q + (m_q << 1);
      3'b100:         p_step = p_q - (m_q << 1);
      3'b101, 3'b110: p_step = p_q - m_q;
      default:        p_step = p_q;
    endcase
`else
    case ({y_q[0], hist_q})
      2'b01:   p_step = p_q + m_q;
      2'b10:   p_step = p_q - m_q;
      default: p_step = p_q;
    endcase
`endif
  end

  always_comb begin
    p_d    = p_q;
    m_d    = m_q;
    y_d    = y_q;
    hist_d = hist_q;
    cnt_d  = cnt_q;
    z_d    = z_q;
    if (accept) begin
      p_d    = '0;
      m_d    = {{(PW - X_WIDTH){x_sx}}, x_in};
      y_d    = {{(YR - Y_WIDTH){y_sx}}, y_in};
      hist_d = 1'b0;
      cnt_d  = '0;
    end else if (state_q == BUSY) begin
      p_d   = p_step;
      cnt_d = cnt_q + CW'(1);
`ifdef SEQ_BOOTH_RADIX4_EN
      m_d    = m_q << 2;
      y_d    = y_q >> 2;
      hist_d = y_q[1];
`else
      m_d    = m_q << 1;
      y_d    = y_q >> 1;
      hist_d = y_q[0];
`endif
      if (last_step) z_d = p_step[ZW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q    <= '0;
      m_q    <= '0;
      y_q    <= '0;
      hist_q <= 1'b0;
      cnt_q  <= '0;
      z_q    <= '0;
    end else begin
      p_q    <= p_d;
      m_q    <= m_d;
      y_q    <= y_d;
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
      z_q    <= z_d;
    end
  end

  assign z_out = z_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Scoreboard bench for seq_booth_multiplier (8x8): driver pushes expected products, monitor pops on handshake.
module tb_seq_booth_multiplier;

`ifdef SEQ_BOOTH_RADIX4_EN
  localparam int ITER = 5;
`else
  localparam int ITER = 9;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  x_in = '0;
  logic [7:0]  y_in = '0;
  logic        signed_op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] z_out;
  logic        busy;

  seq_booth_multiplier #(.X_WIDTH(8), .Y_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .signed_op(signed_op), .out_valid(out_valid),
    .out_ready(out_ready), .z_out(z_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] z;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Monitor: latency on each out_valid rise, product on each output handshake.
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) timeout("unexpected_out_valid");
        else check("latency", cyc - sb[0].acc, ITER);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        check("product", z_out, sb[0].z);
        void'(sb.pop_front());
      end
      prev_v = out_valid;
    end
  end

  task automatic issue(input logic s, input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
    exp_t ent;
    int   n;
    @(posedge clk); #1;
    in_valid = 1'b1; signed_op = s; x_in = x; y_in = y;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 40);
    if (!in_ready) begin
      timeout("in_ready_wait");
      in_valid = 1'b0;
      return;
    end
    ent.z = e;
    ent.acc = cyc + 1;
    sb.push_back(ent);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_in = 8'($urandom);
    y_in = 8'($urandom);
    signed_op = 1'($urandom);
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    if (!out_valid) timeout("out_valid_wait");
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      timeout("drain");
      sb.delete();
    end
  endtask

  typedef struct {
    logic        s;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] z;
  } vec_t;

  vec_t vecs[12] = '{
    '{1'b1, 8'h80, 8'h80, 16'h4000},  // -128 * -128
    '{1'b1, 8'h80, 8'h7F, 16'hC080},  // -128 * 127
    '{1'b1, 8'h00, 8'hFF, 16'h0000},  // 0 * -1
    '{1'b0, 8'hC8, 8'hC8, 16'h9C40},  // 200 * 200
    '{1'b1, 8'hC8, 8'hC8, 16'h0C40},  // -56 * -56
    '{1'b0, 8'hFF, 8'hFF, 16'hFE01},  // 255 * 255
    '{1'b1, 8'hFF, 8'h01, 16'hFFFF},  // -1 * 1
    '{1'b0, 8'h80, 8'h80, 16'h4000},  // 128 * 128
    '{1'b1, 8'h7F, 8'h7F, 16'h3F01},  // 127 * 127
    '{1'b0, 8'h01, 8'hFF, 16'h00FF},  // 1 * 255
    '{1'b1, 8'h55, 8'hAA, 16'hE372},  // 85 * -86
    '{1'b0, 8'h55, 8'hAA, 16'h3872}   // 85 * 170
  };

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_z_out", z_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // -48 * -75, full-rate consumer
    issue(1'b1, 8'hD0, 8'hB5, 16'h0E10);
    @(negedge clk);
    check("busy_in_busy", busy, 1);
    check("in_ready_in_busy", in_ready, 0);
    wait_valid();
    @(negedge clk);
    check("in_ready_after_hs", in_ready, 1);
    check("out_valid_after_hs", out_valid, 0);

    foreach (vecs[i]) begin
      issue(vecs[i].s, vecs[i].x, vecs[i].y, vecs[i].z);
      drain();
    end

    // Backpressure: -5 * 7 held for 5 cycles while a stray request is offered
    out_ready = 1'b0;
    issue(1'b1, 8'hFB, 8'h07, 16'hFFDD);
    wait_valid();
    in_valid = 1'b1; x_in = 8'h11; y_in = 8'h22; signed_op = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_z_out", z_out, 16'hFFDD);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    check("bp_z_hold", z_out, 16'hFFDD);
    check("bp_sb_empty", sb.size(), 0);

    // Reset on BUSY cycle 4 abandons 3 * 4
    issue(1'b1, 8'h03, 8'h04, 16'h000C);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_z_out", z_out, 0);
    issue(1'b1, 8'h05, 8'h06, 16'h001E);
    drain();
    repeat (15) @(negedge clk);
    check("no_extra_output", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
